// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if: request fields from the program source and the instruction-memory write port
interface instruction_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  format;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immediate;
  logic        mem_write_enable;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  modport master (
    output in_valid, format, opcode, rd, rs1, rs2, funct3, funct7, immediate, mem_ready,
    input  in_ready, mem_write_enable, mem_address, mem_write_data
  );
  modport slave (
    input  in_valid, format, opcode, rd, rs1, rs2, funct3, funct7, immediate, mem_ready,
    output in_ready, mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32I fields into words, range-checks immediates, writes to sequential memory addresses
module instruction_encoder #(
  parameter int ERROR_COUNT_WIDTH = 8,
  parameter int WORD_COUNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         finish,
  input  logic [31:0]                  base_address,
  instruction_encoder_if.slave         bus,
  output logic                         range_error,
  output logic [ERROR_COUNT_WIDTH-1:0] error_count,
  output logic [WORD_COUNT_WIDTH-1:0]  word_count,
  output logic                         done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic accept, hs, legal;
  logic [31:0] word, imm;
  logic signed [31:0] simm;
  assign imm = bus.immediate;
  assign simm = bus.immediate;
  assign hs = bus.mem_write_enable && bus.mem_ready;
  assign bus.in_ready = (state == RUN) && (!bus.mem_write_enable || bus.mem_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign done = state == DONE;
  always_comb begin
    word = bus.format == 3'd0 ? {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode} :
           bus.format == 3'd1 ? {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode} :
           bus.format == 3'd2 ? {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode} :
           bus.format == 3'd3 ? {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11], bus.opcode} :
           bus.format == 3'd4 ? {imm[31:12], bus.rd, bus.opcode} :
                                {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
    legal = bus.format == 3'd0 ? 1'b1 :
            (bus.format == 3'd1 || bus.format == 3'd2) ? (simm >= -32'sd2048 && simm <= 32'sd2047) :
            bus.format == 3'd3 ? (!imm[0] && simm >= -32'sd4096 && simm <= 32'sd4094) :
            bus.format == 3'd4 ? (imm[11:0] == 12'd0) :
            bus.format == 3'd5 ? (!imm[0] && simm >= -32'sd1048576 && simm <= 32'sd1048574) : 1'b0;
  end
  always_comb begin
    state_nx = start ? RUN :
               state == RUN ? (finish ? DRAIN : RUN) :
               state == DRAIN ? (bus.mem_write_enable ? DRAIN : DONE) : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.mem_write_enable <= 1'b0;
      bus.mem_address <= 32'd0;
      bus.mem_write_data <= 32'd0;
      range_error <= 1'b0;
      error_count <= '0;
      word_count <= '0;
    end else if (start) begin
      bus.mem_write_enable <= 1'b0;
      bus.mem_address <= {base_address[31:2], 2'b00};
      range_error <= 1'b0;
      error_count <= '0;
      word_count <= '0;
    end else begin
      range_error <= accept && !legal;
      if (accept && !legal && !(&error_count)) error_count <= error_count + ERROR_COUNT_WIDTH'(1);
      if (hs) begin
        bus.mem_address <= bus.mem_address + 32'd4;
        word_count <= word_count + WORD_COUNT_WIDTH'(1);
      end
      // a new word may load in the same cycle the previous one is taken
      if (accept && legal) begin
        bus.mem_write_enable <= 1'b1;
        bus.mem_write_data <= word;
      end else if (hs) bus.mem_write_enable <= 1'b0;
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: table-driven encoding/range vectors plus stall, wrap, drain and reset sequences
module tb_instruction_encoder;
  logic clk = 0, reset_n = 1, start = 0, finish = 0;
  logic [31:0] base_address = 0;
  logic range_error, done;
  logic [7:0] error_count;
  logic [15:0] word_count;
  int checks = 0, failures = 0;
  instruction_encoder_if bus();
  instruction_encoder dut (
    .clk(clk), .reset_n(reset_n), .start(start), .finish(finish), .base_address(base_address),
    .bus(bus), .range_error(range_error), .error_count(error_count), .word_count(word_count), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] fmt; logic [6:0] op; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [6:0] f7;
    logic [31:0] imm; logic err; logic [31:0] exp;
  } vec_t;
  vec_t vecs[18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.format = v.fmt; bus.opcode = v.op; bus.rd = v.rd; bus.rs1 = v.rs1; bus.rs2 = v.rs2;
    bus.funct3 = v.f3; bus.funct7 = v.f7; bus.immediate = v.imm;
  endtask
  task automatic send(input vec_t v);
    drive(v);
    bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0;
  endtask
  task automatic pulse_start(input logic [31:0] b);
    base_address = b;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  initial begin
    int nw, ne, n;
    vecs[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         1'b0, 32'h00500093};
    vecs[1]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         1'b0, 32'h0020A423};
    vecs[2]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC,  1'b0, 32'hFE208EE3};
    vecs[3]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        1'b0, 32'h402081B3};
    vecs[4]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800,  1'b0, 32'h80000093};
    vecs[5]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,      1'b0, 32'h7FF00093};
    vecs[6]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      1'b1, 32'h0};
    vecs[7]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,         1'b1, 32'h0};
    vecs[8]  = '{3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         1'b1, 32'h0};
    vecs[9]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094,      1'b0, 32'h7E208FE3};
    vecs[10] = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096,      1'b1, 32'h0};
    vecs[11] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000,  1'b0, 32'h800000EF};
    vecs[12] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000,  1'b1, 32'h0};
    vecs[13] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001,  1'b1, 32'h0};
    vecs[14] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,  1'b0, 32'h123452B7};
    vecs[15] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      1'b0, 32'h001000EF};
    vecs[16] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,         1'b1, 32'h0};
    vecs[17] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFF7FF,  1'b1, 32'h0};
    bus.in_valid = 0;
    bus.mem_ready = 1;
    drive(vecs[0]);
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    chk("reset mwe", bus.mem_write_enable, 0);
    chk("reset addr", bus.mem_address, 0);
    chk("reset data", bus.mem_write_data, 0);
    chk("reset word_count", word_count, 0);
    chk("reset error_count", error_count, 0);
    chk("reset done", done, 0);
    chk("reset in_ready", bus.in_ready, 0);
    chk("reset range_error", range_error, 0);
    reset_n = 1;
    @(negedge clk);
    chk("idle in_ready", bus.in_ready, 0);
    pulse_start(32'h102);
    chk("run in_ready", bus.in_ready, 1);
    chk("start addr", bus.mem_address, 32'h100);
    nw = 0;
    ne = 0;
    for (int i = 0; i < 18; i++) begin
      send(vecs[i]);
      if (vecs[i].err) begin
        ne++;
        chk($sformatf("v%0d range_error", i), range_error, 1);
        chk($sformatf("v%0d mwe", i), bus.mem_write_enable, 0);
        chk($sformatf("v%0d error_count", i), error_count, ne);
      end else begin
        chk($sformatf("v%0d mwe", i), bus.mem_write_enable, 1);
        chk($sformatf("v%0d data", i), bus.mem_write_data, vecs[i].exp);
        chk($sformatf("v%0d addr", i), bus.mem_address, 32'h100 + 4 * nw);
        chk($sformatf("v%0d range_error", i), range_error, 0);
        nw++;
      end
      @(negedge clk);
      chk($sformatf("v%0d word_count", i), word_count, nw);
      chk($sformatf("v%0d idle mwe", i), bus.mem_write_enable, 0);
      chk($sformatf("v%0d pulse end", i), range_error, 0);
      chk($sformatf("v%0d next addr", i), bus.mem_address, 32'h100 + 4 * nw);
    end
    pulse_start(32'h200);
    chk("restart error_count", error_count, 0);
    chk("restart word_count", word_count, 0);
    chk("restart addr", bus.mem_address, 32'h200);
    bus.mem_ready = 0;
    drive(vecs[14]);
    bus.in_valid = 1;
    @(negedge clk);
    drive(vecs[15]);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d mwe", k), bus.mem_write_enable, 1);
      chk($sformatf("stall%0d data", k), bus.mem_write_data, 32'h123452B7);
      chk($sformatf("stall%0d addr", k), bus.mem_address, 32'h200);
      chk($sformatf("stall%0d in_ready", k), bus.in_ready, 0);
      @(negedge clk);
    end
    bus.mem_ready = 1;
    #1 chk("unstall in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 0;
    chk("b2b data", bus.mem_write_data, 32'h001000EF);
    chk("b2b addr", bus.mem_address, 32'h204);
    chk("b2b word_count", word_count, 1);
    chk("b2b mwe", bus.mem_write_enable, 1);
    @(negedge clk);
    chk("b2b drained count", word_count, 2);
    chk("b2b drained mwe", bus.mem_write_enable, 0);
    chk("b2b drained addr", bus.mem_address, 32'h208);
    pulse_start(32'hFFFFFFFF);
    chk("wrap base", bus.mem_address, 32'hFFFFFFFC);
    send(vecs[0]);
    chk("wrap first addr", bus.mem_address, 32'hFFFFFFFC);
    chk("wrap first data", bus.mem_write_data, 32'h00500093);
    send(vecs[5]);
    chk("wrap second addr", bus.mem_address, 32'h0);
    chk("wrap second data", bus.mem_write_data, 32'h7FF00093);
    chk("wrap word_count", word_count, 1);
    @(negedge clk);
    chk("wrap final count", word_count, 2);
    chk("wrap final addr", bus.mem_address, 32'h4);
    pulse_start(32'h300);
    bus.mem_ready = 0;
    send(vecs[0]);
    finish = 1;
    @(negedge clk);
    finish = 0;
    chk("drain done", done, 0);
    chk("drain in_ready", bus.in_ready, 0);
    chk("drain mwe", bus.mem_write_enable, 1);
    repeat (2) @(negedge clk);
    chk("drain held mwe", bus.mem_write_enable, 1);
    chk("drain held data", bus.mem_write_data, 32'h00500093);
    chk("drain held done", done, 0);
    bus.mem_ready = 1;
    @(negedge clk);
    chk("drain hs mwe", bus.mem_write_enable, 0);
    chk("drain hs count", word_count, 1);
    chk("drain hs done", done, 0);
    n = 0;
    while (!done && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("done reached", done, 1);
    chk("done latency", n, 1);
    base_address = 32'h400;
    start = 1;
    finish = 1;
    @(negedge clk);
    start = 0;
    finish = 0;
    chk("start wins done", done, 0);
    chk("start wins in_ready", bus.in_ready, 1);
    chk("start wins addr", bus.mem_address, 32'h400);
    chk("start wins count", word_count, 0);
    bus.mem_ready = 0;
    send(vecs[1]);
    chk("pre-reset mwe", bus.mem_write_enable, 1);
    #2 reset_n = 0;
    #1;
    chk("async reset mwe", bus.mem_write_enable, 0);
    chk("async reset addr", bus.mem_address, 0);
    chk("async reset data", bus.mem_write_data, 0);
    chk("async reset count", word_count, 0);
    chk("async reset in_ready", bus.in_ready, 0);
    chk("async reset done", done, 0);
    @(negedge clk);
    reset_n = 1;
    bus.mem_ready = 1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
